// File: rtl/dllp_ack_scheduler.sv
// ACK/NAK DLLP scheduler for the RX data link path: coalesces good-TLP ACKs, runs the
// ACK latency timer, keeps at most one NAK outstanding and drives one DLLP word at a time.
module dllp_ack_scheduler #(
    parameter int unsigned ACK_COALESCE = 4,
    parameter int unsigned ACK_TIMEOUT  = 64,
    parameter int unsigned SEQ_W        = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_ack,
    input  logic             rx_nack,
    input  logic [SEQ_W-1:0] rx_seq,
    output logic [31:0]      dllp_data,
    output logic             dllp_valid,
    input  logic             dllp_ready,
    output logic             nak_scheduled,
    output logic             ack_pending
);

    localparam int unsigned CntW = 4;
    localparam int unsigned TmrW = 16;

    localparam logic [7:0]      TypeAck     = 8'h00;
    localparam logic [7:0]      TypeNak     = 8'h10;
    localparam logic [CntW-1:0] CoalesceMax = CntW'(ACK_COALESCE);
    localparam logic [TmrW-1:0] TimeoutLast = TmrW'(ACK_TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e          r_state;
    state_e          w_state_next;

    logic            r_ack_pending;
    logic            w_ack_pending_next;
    logic [SEQ_W-1:0] r_ack_seq;
    logic [SEQ_W-1:0] w_ack_seq_next;
    logic [CntW-1:0] r_ack_cnt;
    logic [CntW-1:0] w_ack_cnt_next;
    logic            r_nak_req;
    logic            w_nak_req_next;
    logic [SEQ_W-1:0] r_nak_seq;
    logic [SEQ_W-1:0] w_nak_seq_next;
    logic            r_nak_sched;
    logic            w_nak_sched_next;
    logic [TmrW-1:0] r_timer;
    logic [TmrW-1:0] w_timer_next;
    logic [31:0]     r_dllp_data;
    logic [31:0]     w_dllp_data_next;

    logic            w_ack_evt;
    logic            w_nack_evt;
    logic            w_fire_nak;
    logic            w_fire_ack;
    logic            w_fire;

    // A simultaneous NAK wins and swallows the ACK; a second NAK is ignored while one is scheduled.
    assign w_nack_evt = rx_nack && !r_nak_sched;
    assign w_ack_evt  = rx_ack && !rx_nack;

    assign w_fire_nak = (r_state == StIdle) && r_nak_req;
    assign w_fire_ack = (r_state == StIdle) && !r_nak_req && r_ack_pending &&
                        ((r_ack_cnt >= CoalesceMax) || (r_timer >= TimeoutLast));
    assign w_fire     = w_fire_nak || w_fire_ack;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_fire) begin
                    w_state_next = StSend;
                end
            end
            StSend: begin
                if (dllp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        dllp_valid = 1'b0;
        unique case (r_state)
            StSend:  dllp_valid = 1'b1;
            default: dllp_valid = 1'b0;
        endcase
    end

    // Pending-state update: a fire clears the owed ACK first, then same-cycle events apply.
    always_comb begin
        w_ack_pending_next = r_ack_pending;
        w_ack_seq_next     = r_ack_seq;
        w_ack_cnt_next     = r_ack_cnt;
        w_nak_req_next     = r_nak_req;
        w_nak_seq_next     = r_nak_seq;
        w_nak_sched_next   = r_nak_sched;
        w_dllp_data_next   = r_dllp_data;

        if (w_fire_nak) begin
            w_dllp_data_next   = {TypeNak, 24'(r_nak_seq)};
            w_nak_req_next     = 1'b0;
            w_ack_pending_next = 1'b0;
            w_ack_cnt_next     = '0;
        end else if (w_fire_ack) begin
            w_dllp_data_next   = {TypeAck, 24'(r_ack_seq)};
            w_ack_pending_next = 1'b0;
            w_ack_cnt_next     = '0;
        end

        if (w_nack_evt) begin
            w_nak_req_next   = 1'b1;
            w_nak_sched_next = 1'b1;
            w_nak_seq_next   = rx_seq;
        end else if (w_ack_evt) begin
            w_ack_pending_next = 1'b1;
            w_ack_seq_next     = rx_seq;
            w_nak_sched_next   = 1'b0;
            if (w_ack_cnt_next < CoalesceMax) begin
                w_ack_cnt_next = w_ack_cnt_next + CntW'(1);
            end
        end
    end

    // ACK latency timer: runs only while an ACK is owed and the slot is free
    always_comb begin
        w_timer_next = r_timer;
        if (w_fire || !w_ack_pending_next) begin
            w_timer_next = '0;
        end else if ((r_state == StIdle) && r_ack_pending && (r_timer != '1)) begin
            w_timer_next = r_timer + TmrW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_pending <= 1'b0;
            r_ack_seq     <= '0;
            r_ack_cnt     <= '0;
            r_nak_req     <= 1'b0;
            r_nak_seq     <= '0;
            r_nak_sched   <= 1'b0;
            r_timer       <= '0;
            r_dllp_data   <= '0;
        end else begin
            r_ack_pending <= w_ack_pending_next;
            r_ack_seq     <= w_ack_seq_next;
            r_ack_cnt     <= w_ack_cnt_next;
            r_nak_req     <= w_nak_req_next;
            r_nak_seq     <= w_nak_seq_next;
            r_nak_sched   <= w_nak_sched_next;
            r_timer       <= w_timer_next;
            r_dllp_data   <= w_dllp_data_next;
        end
    end

    assign dllp_data     = r_dllp_data;
    assign nak_scheduled = r_nak_sched;
    assign ack_pending   = r_ack_pending;

    a_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (dllp_valid && !dllp_ready) |=> (dllp_valid && $stable(dllp_data)));

endmodule

// File: tb/tb_dllp_ack_scheduler.sv
// Self-checking bench for dllp_ack_scheduler: directed vector table, corner-case sequences
// and randomized traffic against an event-level reference model.
module tb_dllp_ack_scheduler;

    localparam int unsigned C = 4;
    localparam int unsigned T = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_ack = 1'b0;
    logic        rx_nack = 1'b0;
    logic [11:0] rx_seq = '0;
    logic [31:0] dllp_data;
    logic        dllp_valid;
    logic        dllp_ready = 1'b0;
    logic        nak_scheduled;
    logic        ack_pending;

    int n_checks = 0;
    int n_errors = 0;

    dllp_ack_scheduler #(
        .ACK_COALESCE(C),
        .ACK_TIMEOUT (T),
        .SEQ_W       (12)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_ack       (rx_ack),
        .rx_nack      (rx_nack),
        .rx_seq       (rx_seq),
        .dllp_data    (dllp_data),
        .dllp_valid   (dllp_valid),
        .dllp_ready   (dllp_ready),
        .nak_scheduled(nak_scheduled),
        .ack_pending  (ack_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic        nack;
        logic [11:0] seq;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        ens;
        logic        eap;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(input logic a, input logic n, input logic [11:0] s,
                                input logic r, input logic v, input logic [31:0] d,
                                input logic ns, input logic ap);
        vec_t x;
        x.ack = a; x.nack = n; x.seq = s; x.rdy = r;
        x.ev = v; x.ed = d; x.ens = ns; x.eap = ap;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, let the edge pass, sample 1 time unit later.
    task automatic cycle(input logic a, input logic n, input logic [11:0] s, input logic r);
        rx_ack = a; rx_nack = n; rx_seq = s; dllp_ready = r;
        @(posedge clk);
        #1;
        rx_ack = 1'b0; rx_nack = 1'b0;
    endtask

    task automatic reset_dut();
        reset_n = 1'b0; rx_ack = 1'b0; rx_nack = 1'b0; dllp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Idle with ready high until dllp_valid rises; returns edges waited (bounded).
    task automatic wait_valid(output int k);
        k = 0;
        do begin
            cycle(1'b0, 1'b0, 12'h0, 1'b1);
            k++;
        end while (!dllp_valid && k < 300);
    endtask

    // Reference model: owed ACK bookkeeping plus a busy/idle link slot.
    bit          m_busy, m_pend, m_nreq, m_nsched;
    logic [31:0] m_word;
    logic [11:0] m_seq, m_nseq;
    int          m_cnt, m_wait;

    task automatic model_reset();
        m_busy = 0; m_pend = 0; m_nreq = 0; m_nsched = 0;
        m_word = '0; m_seq = '0; m_nseq = '0; m_cnt = 0; m_wait = 0;
    endtask

    task automatic model_step(input bit a, input bit n, input logic [11:0] s, input bit r);
        bit free, send_nak, send_ack;
        free     = !m_busy;
        send_nak = free && m_nreq;
        send_ack = free && !m_nreq && m_pend && (m_cnt >= C || m_wait + 1 >= T);
        if (m_busy && r) m_busy = 0;
        if (send_nak) begin
            m_busy = 1; m_word = {8'h10, 12'h000, m_nseq};
            m_nreq = 0; m_pend = 0; m_cnt = 0; m_wait = 0;
        end else if (send_ack) begin
            m_busy = 1; m_word = {8'h00, 12'h000, m_seq};
            m_pend = 0; m_cnt = 0; m_wait = 0;
        end else if (free && m_pend) begin
            m_wait++;
        end
        if (n) begin
            if (!m_nsched) begin
                m_nreq = 1; m_nsched = 1; m_nseq = s;
            end
        end else if (a) begin
            m_pend = 1; m_seq = s; m_nsched = 0;
            m_cnt = (m_cnt + 1 > C) ? C : m_cnt + 1;
        end
    endtask

    initial begin
        int k;
        bit seen;
        logic [31:0] held;

        // Coalesce, NAK suppression, simultaneous ack+nack
        vt[0]  = mk(1'b1, 1'b0, 12'd1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1);
        vt[1]  = mk(1'b1, 1'b0, 12'd2, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1);
        vt[2]  = mk(1'b1, 1'b0, 12'd3, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1);
        vt[3]  = mk(1'b1, 1'b0, 12'd4, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1);
        vt[4]  = mk(1'b0, 1'b0, 12'd0, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 1'b0);
        vt[5]  = mk(1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0);
        vt[6]  = mk(1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0);
        vt[7]  = mk(1'b1, 1'b0, 12'd5, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1);
        vt[8]  = mk(1'b0, 1'b1, 12'd5, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1);
        vt[9]  = mk(1'b0, 1'b1, 12'd5, 1'b1, 1'b1, 32'h1000_0005, 1'b1, 1'b0);
        vt[10] = mk(1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0);
        vt[11] = mk(1'b1, 1'b0, 12'd6, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1);
        vt[12] = mk(1'b1, 1'b1, 12'd9, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1);
        vt[13] = mk(1'b0, 1'b0, 12'd0, 1'b1, 1'b1, 32'h1000_0009, 1'b1, 1'b0);
        vt[14] = mk(1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0);

        reset_dut();
        check("reset_valid", 32'(dllp_valid), 32'd0);
        check("reset_data", dllp_data, 32'd0);
        check("reset_nak_sched", 32'(nak_scheduled), 32'd0);
        check("reset_ack_pending", 32'(ack_pending), 32'd0);

        for (int i = 0; i < 15; i++) begin
            cycle(vt[i].ack, vt[i].nack, vt[i].seq, vt[i].rdy);
            check($sformatf("vec%0d_valid", i), 32'(dllp_valid), 32'(vt[i].ev));
            if (vt[i].ev) check($sformatf("vec%0d_data", i), dllp_data, vt[i].ed);
            check($sformatf("vec%0d_nak_sched", i), 32'(nak_scheduled), 32'(vt[i].ens));
            check($sformatf("vec%0d_ack_pending", i), 32'(ack_pending), 32'(vt[i].eap));
        end

        // Good TLP after the NAK: ACK goes out on the latency timer
        cycle(1'b1, 1'b0, 12'd6, 1'b1);
        check("ack6_clears_nak_sched", 32'(nak_scheduled), 32'd0);
        wait_valid(k);
        check("ack6_latency", 32'(k), 32'd64);
        check("ack6_data", dllp_data, 32'h0000_0006);
        cycle(1'b0, 1'b0, 12'h0, 1'b1);

        // Timeout from a fresh reset
        reset_dut();
        cycle(1'b1, 1'b0, 12'h07F, 1'b1);
        check("tmo_ack_pending", 32'(ack_pending), 32'd1);
        wait_valid(k);
        check("tmo_latency", 32'(k), 32'd64);
        check("tmo_data", dllp_data, 32'h0000_007F);

        // Backpressure with a NAK arriving mid-stall
        reset_dut();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 12'(i), 1'b0);
        cycle(1'b0, 1'b0, 12'h0, 1'b0);
        check("bp_valid", 32'(dllp_valid), 32'd1);
        check("bp_data", dllp_data, 32'h0000_0003);
        held = dllp_data;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, i == 10, 12'd3, 1'b0);
            if (!dllp_valid || dllp_data !== held) seen = 1'b1;
        end
        check("bp_stable_20", 32'(seen), 32'd0);
        check("bp_nak_sched", 32'(nak_scheduled), 32'd1);
        cycle(1'b0, 1'b0, 12'h0, 1'b1);
        check("bp_gap", 32'(dllp_valid), 32'd0);
        cycle(1'b0, 1'b0, 12'h0, 1'b1);
        check("bp_nak_valid", 32'(dllp_valid), 32'd1);
        check("bp_nak_data", dllp_data, 32'h1000_0003);
        cycle(1'b0, 1'b0, 12'h0, 1'b1);

        // Asynchronous reset while a DLLP is on the wire
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 12'(i), 1'b0);
        cycle(1'b0, 1'b0, 12'h0, 1'b0);
        cycle(1'b1, 1'b0, 12'd9, 1'b0);
        cycle(1'b0, 1'b1, 12'd9, 1'b0);
        check("pre_rst_state", {29'd0, dllp_valid, nak_scheduled, ack_pending}, 32'd7);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(dllp_valid), 32'd0);
        check("async_rst_nak_sched", 32'(nak_scheduled), 32'd0);
        check("async_rst_ack_pending", 32'(ack_pending), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b0, 12'h0, 1'b1);
            if (dllp_valid) seen = 1'b1;
        end
        check("post_rst_silent", 32'(seen), 32'd0);

        // Randomized traffic against the reference model
        reset_dut();
        model_reset();
        for (int i = 0; i < 4000; i++) begin
            bit a, n, r;
            logic [11:0] s;
            int mode;
            mode = (i / 500) % 4;
            a = (mode == 1 || mode == 3) ? ($urandom_range(99) < 2) : ($urandom_range(99) < 50);
            n = (mode == 2) ? ($urandom_range(99) < 8) : ($urandom_range(99) < 1);
            r = (mode >= 2) ? ($urandom_range(99) < 30) : ($urandom_range(99) < 80);
            s = 12'($urandom);
            cycle(a, n, s, r);
            model_step(a, n, s, r);
            check($sformatf("rnd%0d_valid", i), 32'(dllp_valid), 32'(m_busy));
            if (m_busy) check($sformatf("rnd%0d_data", i), dllp_data, m_word);
            check($sformatf("rnd%0d_nak_sched", i), 32'(nak_scheduled), 32'(m_nsched));
            check($sformatf("rnd%0d_ack_pending", i), 32'(ack_pending), 32'(m_pend));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dllp_ack_scheduler.md
Name: dllp_ack_scheduler

Overview:
- Schedules ACK/NAK DLLPs for the RX data link path.
- Consumes per-TLP ack/nack pulses and their sequence numbers from the RX data link layer, coalesces ACKs, runs the ACK latency timer and enforces the single-outstanding-NAK rule.
- Emits one 32-bit DLLP word at a time to the TX physical-layer DLLP slot over a valid/ready handshake.

Parameters:
- ACK_COALESCE, 4: number of good TLPs after which an ACK is sent immediately; range 1..15.
- ACK_TIMEOUT, 64: cycles a pending ACK may wait before forced transmission; range 2..65535.
- SEQ_W, 12: sequence-number width.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- rx_ack  input  1  one-cycle pulse: TLP received good; rx_seq is its sequence number
- rx_nack  input  1  one-cycle pulse: TLP bad (LCRC or sequence error); rx_seq is the last good sequence number
- rx_seq  input  SEQ_W  sequence number qualified by rx_ack or rx_nack
- dllp_data  output  32  DLLP word: [31:24] type (8'h00 ACK, 8'h10 NAK), [23:SEQ_W] zero, [SEQ_W-1:0] sequence
- dllp_valid  output  1  dllp_data valid
- dllp_ready  input  1  TX physical layer accepts the word
- nak_scheduled  output  1  a NAK has been accepted and no good TLP has been seen since
- ack_pending  output  1  ACK owed, not yet issued

Behaviour:
- Reset (async assert, sync-released use): dllp_valid=0, dllp_data=0, nak_scheduled=0, ack_pending=0, coalesce count=0, timer=0, FSM=IDLE.
- Internal state: ack_pending, ack_seq (latest rx_ack seq), ack_cnt (0..ACK_COALESCE, saturating), nak_req, nak_seq, timer.
- rx_ack:
  - Sets ack_pending and loads ack_seq=rx_seq.
  - Increments ack_cnt (saturating at ACK_COALESCE).
  - Clears nak_scheduled.
- rx_nack:
  - If nak_scheduled=0: sets nak_req and nak_scheduled, loads nak_seq=rx_seq.
  - If nak_scheduled=1: ignored entirely.
- rx_ack and rx_nack in the same cycle: rx_nack wins; the rx_ack is dropped and nak_scheduled is not cleared.
- Timer:
  - Counts +1 per cycle while ack_pending=1 and FSM=IDLE; holds in SEND.
  - Zeroed whenever ack_pending is cleared.
- FSM IDLE: a trigger condition evaluated on registered state loads dllp_data and sets dllp_valid the next cycle (1-cycle latency), then moves to SEND. Triggers in priority order:
  1. nak_req=1: load NAK with nak_seq; clears nak_req and also ack_pending/ack_cnt/timer (the NAK acknowledges up to nak_seq).
  2. ack_pending=1 and (ack_cnt>=ACK_COALESCE or timer>=ACK_TIMEOUT-1): load ACK with ack_seq; clears ack_pending, ack_cnt and timer.
- FSM SEND:
  - dllp_valid and dllp_data are held stable until dllp_valid&dllp_ready.
  - On handshake: dllp_valid=0 the next cycle, return to IDLE. Back-to-back DLLPs therefore have at least one idle cycle between them.
- Events arriving during SEND update pending state normally and are never lost. A NAK raised during an ACK send is issued on the next IDLE evaluation.
- Deassertion of dllp_ready for any number of cycles: output stable, no timeout, no drop.
- Sequence values pass through unmodified; no modulo arithmetic is performed in this block.
- Reset mid-SEND: dllp_valid drops immediately (async) and all pending state is discarded.

Test Plan:
- Coalesce: ACK_COALESCE=4, dllp_ready=1; rx_ack with seq 1,2,3,4 on consecutive cycles -> exactly one DLLP 32'h0000_0004 one cycle after ack_cnt reaches 4; ack_pending=0 afterwards.
- Timeout: ACK_TIMEOUT=64; single rx_ack seq 12'h07F, then idle -> ACK 32'h0000_007F asserted 64 cycles after ack_pending rose; no DLLP before that.
- NAK priority/suppression: rx_ack seq 5, then rx_nack seq 5, then rx_nack seq 5 again -> one NAK 32'h1000_0005, no ACK, nak_scheduled=1. A following rx_ack seq 6 clears nak_scheduled; after 64 idle cycles, ACK 32'h0000_0006 is sent.
- Simultaneous: rx_ack and rx_nack in the same cycle with seq 9 -> NAK 32'h1000_0009 only; nak_scheduled stays 1.
- Backpressure: dllp_ready=0 for 20 cycles while an ACK seq 3 is valid, with rx_nack seq 3 arriving mid-stall -> ACK word held stable 20 cycles; after the handshake, NAK 32'h1000_0003 follows with one idle cycle gap.
- Reset mid-operation: assert reset_n=0 while dllp_valid=1 -> dllp_valid, nak_scheduled and ack_pending go 0 asynchronously; no DLLP is emitted after release until new rx_ack/rx_nack.
